// File: rtl/sio_pkg.sv
// Shared constants and state encoding for the remote-end serial IO engine.
package sio_pkg;

    localparam int NA       = 7;
    localparam int ND       = 32;
    localparam int NBT      = 1 + NA + ND;
    localparam int TA       = 16;
    localparam int PRE_LEN  = 2;
    localparam int CW       = 6;

    localparam int RW_POS   = NBT - 1;
    localparam int ADDR_LSB = ND;
    localparam int DATA_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        TURN,
        PRE,
        TX,
        GUARD
    } state_t;

endpackage

// File: rtl/sio_remote_tx.sv
// Response serialiser: start bit plus ND data bits MSB first, then one stop bit.
module sio_remote_tx
    import sio_pkg::*;
(
    input  logic          c,
    input  logic          rst_n,
    input  logic          pre,
    input  logic          load,
    input  logic [ND-1:0] data,
    output logic          sdo,
    output logic          t,
    output logic          done
);

    localparam int NS = ND + 1;

    logic [NS-1:0] sh;
    logic [CW-1:0] bit_cnt;
    logic          busy;

    // done marks the stop-bit cycle, the last cycle the line is driven
    assign done = busy && (bit_cnt == CW'(NS));

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            sh      <= '1;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else if (load) begin
            sh      <= {1'b0, data};
            bit_cnt <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else begin
                sh      <= {sh[NS-2:0], 1'b1};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        t   = !(pre || busy);
        sdo = 1'b1;
        if (busy && !done) begin
            sdo = sh[NS-1];
        end
    end

endmodule

// File: rtl/sio_remote.sv
// Device-side serial IO engine: receives host frames, strobes the register
// file, and returns read data on the shared half-duplex line.
//
// state | meaning
// IDLE  | line idle, waiting for a start bit on s2
// RX    | shifting in NBT payload bits
// TURN  | line released for TA cycles, collecting rd_ack
// PRE   | driving two idle-high bits before the response
// TX    | driving start, data and stop bits
// GUARD | line released, waiting for two consecutive high samples
module sio_remote
    import sio_pkg::*;
(
    input  logic          c,
    input  logic          rst_n,
    input  logic          sdi,
    output logic          sdo,
    output logic          t,
    output logic          wr,
    output logic          rd,
    output logic [NA-1:0] addr,
    output logic [ND-1:0] wdata,
    input  logic          rd_ack,
    input  logic [ND-1:0] rd_data,
    output logic          err
);

    state_t         state;
    state_t         state_nx;
    logic           s1;
    logic           s2;
    logic [CW-1:0]  cnt;
    logic [NBT-2:0] sh;
    logic [NBT-1:0] frame;
    logic           acked;
    logic [ND-1:0]  rsp;

    logic rx_last;
    logic ta_last;
    logic pre_last;
    logic ack_take;
    logic have_data;
    logic tx_done;

    assign frame     = {sh, s2};
    assign rx_last   = (state == RX)   && (cnt == CW'(NBT - 1));
    assign ta_last   = (state == TURN) && (cnt == CW'(TA - 1));
    assign pre_last  = (state == PRE)  && (cnt == CW'(PRE_LEN - 1));
    // an ack in the same cycle as the rd strobe cannot belong to this request
    assign ack_take  = (state == TURN) && !rd && !acked && rd_ack;
    assign have_data = acked || ack_take;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!s2) state_nx = RX;
            RX:      if (rx_last) state_nx = frame[RW_POS] ? TURN : IDLE;
            TURN:    if (ta_last) state_nx = have_data ? PRE : GUARD;
            PRE:     if (pre_last) state_nx = TX;
            TX:      if (tx_done) state_nx = GUARD;
            GUARD:   if (s2 && (cnt == CW'(1))) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            s1    <= sdi;
            s2    <= s1;
            state <= state_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else begin
                case (state)
                    RX, TURN, PRE: cnt <= cnt + 1'b1;
                    GUARD:         cnt <= s2 ? cnt + 1'b1 : '0;
                    default:       cnt <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            sh    <= '0;
            wr    <= 1'b0;
            rd    <= 1'b0;
            err   <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            acked <= 1'b0;
            rsp   <= '0;
        end else begin
            wr  <= 1'b0;
            rd  <= 1'b0;
            err <= 1'b0;
            if (state == RX) begin
                sh <= {sh[NBT-3:0], s2};
                if (rx_last) begin
                    addr <= frame[ADDR_LSB +: NA];
                    if (frame[RW_POS]) begin
                        rd    <= 1'b1;
                        acked <= 1'b0;
                    end else begin
                        wr    <= 1'b1;
                        wdata <= frame[DATA_LSB +: ND];
                    end
                end
            end
            if (ack_take) begin
                acked <= 1'b1;
                rsp   <= rd_data;
            end
            if (ta_last && !have_data) begin
                err <= 1'b1;
            end
        end
    end

    sio_remote_tx u_tx (
        .c     (c),
        .rst_n (rst_n),
        .pre   (state == PRE),
        .load  (pre_last),
        .data  (rsp),
        .sdo   (sdo),
        .t     (t),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_sio_remote.sv
// Directed bench for sio_remote: host frames driven bit by bit, line modelled
// as host drive when the remote is tristated, remote sdo otherwise.
module tb_sio_remote;

    logic        c = 1'b0;
    logic        rst_n;
    logic        host_bit;
    logic        sdi;
    logic        sdo;
    logic        t;
    logic        wr;
    logic        rd;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, t_low = 0;
    int          wr_last_cyc = 0, wr_prev_cyc = 0, rd_last_cyc = 0;
    int          err_last_cyc = 0, t_fall_cyc = 0;
    logic [6:0]  wr_last_addr = '0, wr_prev_addr = '0;
    logic [31:0] wr_last_data = '0, wr_prev_data = '0;
    logic [63:0] resp = '0;
    logic        t_prev = 1'b1;
    logic        both = 1'b0;

    assign sdi = t ? host_bit : sdo;

    sio_remote dut (
        .c       (c),
        .rst_n   (rst_n),
        .sdi     (sdi),
        .sdo     (sdo),
        .t       (t),
        .wr      (wr),
        .rd      (rd),
        .addr    (addr),
        .wdata   (wdata),
        .rd_ack  (rd_ack),
        .rd_data (rd_data),
        .err     (err)
    );

    always #5 c = ~c;

    always @(posedge c) cyc <= cyc + 1;

    always @(negedge c) begin
        if (wr) begin
            wr_cnt       <= wr_cnt + 1;
            wr_prev_cyc  <= wr_last_cyc;
            wr_last_cyc  <= cyc;
            wr_prev_addr <= wr_last_addr;
            wr_last_addr <= addr;
            wr_prev_data <= wr_last_data;
            wr_last_data <= wdata;
        end
        if (rd) begin
            rd_cnt      <= rd_cnt + 1;
            rd_last_cyc <= cyc;
        end
        if (err) begin
            err_cnt      <= err_cnt + 1;
            err_last_cyc <= cyc;
        end
        if (wr && rd) both <= 1'b1;
        t_prev <= t;
        if (!t) begin
            t_low <= t_low + 1;
            resp  <= {resp[62:0], sdo};
            if (t_prev) t_fall_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic tick_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic send_frame(input logic [39:0] f, input int nbits, output int start);
        host_bit = 1'b0;
        start = cyc;
        tick();
        for (int i = 39; i > 39 - nbits; i--) begin
            host_bit = f[i];
            tick();
        end
        host_bit = 1'b1;
    endtask

    localparam logic [35:0] RESP_A = {2'b11, 1'b0, 32'hA5A50F0F, 1'b1};
    localparam logic [35:0] RESP_B = {2'b11, 1'b0, 32'h0F1E2D3C, 1'b1};
    localparam logic [35:0] RESP_C = {2'b11, 1'b0, 32'hDEADBEEF, 1'b1};

    initial begin
        int st, r, w0, r0, e0, tl0;

        rst_n = 1'b0; host_bit = 1'b1; rd_ack = 1'b0; rd_data = '0;
        tick(); tick(); tick();
        check("rst_t", 64'(t), 64'(1));
        check("rst_sdo", 64'(sdo), 64'(1));
        check("rst_wr_rd_err", 64'({wr, rd, err}), 64'(0));
        check("rst_addr", 64'(addr), 64'(0));
        check("rst_wdata", 64'(wdata), 64'(0));
        rst_n = 1'b1;
        tick(); tick(); tick();

        // single write
        w0 = wr_cnt; r0 = rd_cnt; tl0 = t_low;
        send_frame({1'b0, 7'h15, 32'h12345678}, 40, st);
        tick_until(st + 50);
        check("w1_count", 64'(wr_cnt - w0), 64'(1));
        check("w1_cycle", 64'(wr_last_cyc), 64'(st + 43));
        check("w1_addr", 64'(wr_last_addr), 64'(7'h15));
        check("w1_data", 64'(wr_last_data), 64'(32'h12345678));
        check("w1_no_rd", 64'(rd_cnt - r0), 64'(0));
        check("w1_t_high", 64'(t_low - tl0), 64'(0));

        // read with ack two cycles after rd
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; tl0 = t_low;
        send_frame({1'b1, 7'h03, 32'h0}, 40, st);
        r = st + 43;
        tick_until(r + 2);
        rd_ack = 1'b1; rd_data = 32'hA5A50F0F;
        tick();
        rd_ack = 1'b0; rd_data = '0;
        tick_until(r + 60);
        check("r1_rd_cycle", 64'(rd_last_cyc), 64'(r));
        check("r1_rd_count", 64'(rd_cnt - r0), 64'(1));
        check("r1_addr", 64'(addr), 64'(7'h03));
        check("r1_wdata_kept", 64'(wdata), 64'(32'h12345678));
        check("r1_t_fall", 64'(t_fall_cyc), 64'(r + 16));
        check("r1_t_low", 64'(t_low - tl0), 64'(36));
        check("r1_resp", 64'(resp[35:0]), 64'(RESP_A));
        check("r1_no_err_wr", 64'((err_cnt - e0) + (wr_cnt - w0)), 64'(0));

        // read with no ack, late ack ignored
        r0 = rd_cnt; e0 = err_cnt; tl0 = t_low;
        send_frame({1'b1, 7'h2A, 32'h0}, 40, st);
        r = st + 43;
        tick_until(r + 19);
        rd_ack = 1'b1; rd_data = 32'hFFFFFFFF;
        tick();
        rd_ack = 1'b0; rd_data = '0;
        tick_until(r + 40);
        check("to_err_count", 64'(err_cnt - e0), 64'(1));
        check("to_err_cycle", 64'(err_last_cyc), 64'(r + 16));
        check("to_t_high", 64'(t_low - tl0), 64'(0));
        check("to_rd_count", 64'(rd_cnt - r0), 64'(1));

        // back-to-back writes with two idle bits
        w0 = wr_cnt;
        send_frame({1'b0, 7'h7F, 32'hFFFF0000}, 40, st);
        tick(); tick();
        send_frame({1'b0, 7'h40, 32'h0000FFFF}, 40, st);
        tick_until(st + 50);
        check("bb_count", 64'(wr_cnt - w0), 64'(2));
        check("bb_spacing", 64'(wr_last_cyc - wr_prev_cyc), 64'(43));
        check("bb_addr0", 64'(wr_prev_addr), 64'(7'h7F));
        check("bb_data0", 64'(wr_prev_data), 64'(32'hFFFF0000));
        check("bb_addr1", 64'(wr_last_addr), 64'(7'h40));
        check("bb_data1", 64'(wr_last_data), 64'(32'h0000FFFF));

        // reset in the middle of a write frame
        w0 = wr_cnt;
        send_frame({1'b0, 7'h3C, 32'hCAFEF00D}, 20, st);
        rst_n = 1'b0;
        #1;
        check("mr_t", 64'(t), 64'(1));
        check("mr_addr", 64'(addr), 64'(0));
        check("mr_wdata", 64'(wdata), 64'(0));
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick_until(cyc + 30);
        check("mr_no_wr", 64'(wr_cnt - w0), 64'(0));

        r0 = rd_cnt; tl0 = t_low;
        send_frame({1'b1, 7'h55, 32'h0}, 40, st);
        r = st + 43;
        tick_until(r + 3);
        rd_ack = 1'b1; rd_data = 32'h0F1E2D3C;
        tick();
        rd_ack = 1'b0; rd_data = '0;
        tick_until(r + 60);
        check("mr_rd_count", 64'(rd_cnt - r0), 64'(1));
        check("mr_rd_addr", 64'(addr), 64'(7'h55));
        check("mr_resp", 64'(resp[35:0]), 64'(RESP_B));
        check("mr_t_low", 64'(t_low - tl0), 64'(36));

        // start bit injected during TURN; acks at rd, rd+1 and rd+3
        w0 = wr_cnt; r0 = rd_cnt; tl0 = t_low;
        send_frame({1'b1, 7'h11, 32'h0}, 40, st);
        r = st + 43;
        tick_until(r);
        rd_ack = 1'b1; rd_data = 32'h11111111;
        tick();
        rd_data = 32'hDEADBEEF;
        tick();
        rd_ack = 1'b0; rd_data = '0;
        tick();
        rd_ack = 1'b1; rd_data = 32'h22222222;
        tick();
        rd_ack = 1'b0; rd_data = '0;
        host_bit = 1'b0;
        tick_until(r + 8);
        host_bit = 1'b1;
        tick_until(r + 60);
        check("inj_resp", 64'(resp[35:0]), 64'(RESP_C));
        check("inj_strobes", 64'((rd_cnt - r0) + (wr_cnt - w0)), 64'(1));
        check("inj_t_low", 64'(t_low - tl0), 64'(36));

        w0 = wr_cnt;
        send_frame({1'b0, 7'h22, 32'h600DF00D}, 40, st);
        tick_until(st + 50);
        check("post_wr_count", 64'(wr_cnt - w0), 64'(1));
        check("post_wr_cycle", 64'(wr_last_cyc), 64'(st + 43));
        check("post_wr_data", 64'(wr_last_data), 64'(32'h600DF00D));
        check("never_both", 64'(both), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
